// File: rtl/pcs_pkg.sv
// Shared 1000BASE-X PCS transmit constants: one-hot ordered-set requests,
// special code-group octets and the transmit ordered-set state encoding.
package pcs_pkg;

    // One-hot ordered-set requests to the code-group transmitter
    localparam logic [4:0] OS_R = 5'b00001;
    localparam logic [4:0] OS_S = 5'b00010;
    localparam logic [4:0] OS_T = 5'b00100;
    localparam logic [4:0] OS_D = 5'b01000;
    localparam logic [4:0] OS_I = 5'b10000;

    // Special code-group octets
    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K23_7 = 8'hF7;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;

    typedef enum logic [2:0] {
        ST_IDLE_1 = 3'd0,
        ST_IDLE_2 = 3'd1,
        ST_SOP    = 3'd2,
        ST_DATA   = 3'd3,
        ST_EOP    = 3'd4,
        ST_EPD2   = 3'd5,
        ST_EPD3   = 3'd6
    } tx_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pcs_tx_ordered_set_if.sv
// GMII transmit side plus ordered-set request bundle of the PCS transmitter.
// master: GMII source / request consumer; slave: the ordered-set FSM.
interface pcs_tx_ordered_set_if;

    logic        TX_EN;
    logic        TX_ER;
    logic [7:0]  TXD;
    logic [4:0]  tx_o_set;
    logic [7:0]  TXD_out;
    logic        tx_even;
    logic [15:0] tx_frame_count;
    logic [7:0]  tx_err_count;

    modport master (
        output TX_EN,
        output TX_ER,
        output TXD,
        input  tx_o_set,
        input  TXD_out,
        input  tx_even,
        input  tx_frame_count,
        input  tx_err_count
    );

    modport slave (
        input  TX_EN,
        input  TX_ER,
        input  TXD,
        output tx_o_set,
        output TXD_out,
        output tx_even,
        output tx_frame_count,
        output tx_err_count
    );

endinterface

// File: rtl/pcs_tx_ordered_set.sv
// 1000BASE-X PCS transmit ordered-set FSM: GMII stream to I/S/D/T/R requests
// with even-slot /I/ alignment, frame counter and data-error counter.
// Ports: clk, mr_main_reset (async, active high), gmii (slave modport).
module pcs_tx_ordered_set
    import pcs_pkg::*;
(
    input  logic                   clk,
    input  logic                   mr_main_reset,
    pcs_tx_ordered_set_if.slave    gmii
);

    tx_state_e   state_q, state_d;
    logic [4:0]  tx_o_set_q, tx_o_set_d;
    logic [7:0]  txd_out_q, txd_out_d;
    logic        tx_even_q, tx_even_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    always_comb begin
        state_d     = state_q;
        tx_o_set_d  = OS_I;
        txd_out_d   = K28_5;
        tx_even_d   = ~tx_even_q;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;

        unique case (state_q)
            ST_IDLE_1: state_d = ST_IDLE_2;
            ST_IDLE_2: state_d = gmii.TX_EN ? ST_SOP : ST_IDLE_1;
            ST_SOP:    state_d = gmii.TX_EN ? ST_DATA : ST_EOP;
            ST_DATA:   state_d = gmii.TX_EN ? ST_DATA : ST_EOP;
            ST_EOP:    state_d = ST_EPD2;
            // A second R is needed when the slot after EPD2 would be odd,
            // so that the following /I/ starts on an even slot.
            ST_EPD2:   state_d = tx_even_q ? ST_EPD3 : ST_IDLE_1;
            ST_EPD3:   state_d = ST_IDLE_1;
            default:   state_d = ST_IDLE_1;
        endcase

        // Outputs are those of the state being entered (registered Moore).
        unique case (state_d)
            ST_SOP: begin
                tx_o_set_d = OS_S;
                txd_out_d  = K27_7;
            end
            ST_DATA: begin
                tx_o_set_d = OS_D;
                txd_out_d  = gmii.TXD;
                if (gmii.TX_ER) begin
                    err_cnt_d = sat_inc8(err_cnt_q);
                end
            end
            ST_EOP: begin
                tx_o_set_d  = OS_T;
                txd_out_d   = K29_7;
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
            ST_EPD2, ST_EPD3: begin
                tx_o_set_d = OS_R;
                txd_out_d  = K23_7;
            end
            default: begin
                tx_o_set_d = OS_I;
                txd_out_d  = K28_5;
            end
        endcase
    end

    always_ff @(posedge clk or posedge mr_main_reset) begin
        if (mr_main_reset) begin
            state_q     <= ST_IDLE_1;
            tx_o_set_q  <= OS_I;
            txd_out_q   <= K28_5;
            tx_even_q   <= 1'b1;
            frame_cnt_q <= 16'd0;
            err_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            tx_o_set_q  <= tx_o_set_d;
            txd_out_q   <= txd_out_d;
            tx_even_q   <= tx_even_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign gmii.tx_o_set       = tx_o_set_q;
    assign gmii.TXD_out        = txd_out_q;
    assign gmii.tx_even        = tx_even_q;
    assign gmii.tx_frame_count = frame_cnt_q;
    assign gmii.tx_err_count   = err_cnt_q;

endmodule

// File: tb/tb_pcs_tx_ordered_set.sv
// Scoreboard bench for pcs_tx_ordered_set: a queue-based reference model
// predicts each output slot; a negedge monitor pops and compares.
module tb_pcs_tx_ordered_set;

    typedef struct {
        logic [4:0]  os;
        logic [7:0]  oct;
        logic        ev;
        logic [15:0] fc;
        logic [7:0]  ec;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    pcs_tx_ordered_set_if bus();

    pcs_tx_ordered_set dut (
        .clk           (clk),
        .mr_main_reset (rst),
        .gmii          (bus)
    );

    // Reference model state
    exp_t       exp_q[$];
    logic [4:0] tail_os[$];
    logic [7:0] tail_oct[$];
    logic       m_even = 1'b1;
    logic       m_in_frame = 1'b0;
    logic [15:0] m_fc = 16'd0;
    int         m_ec = 0;

    task automatic model_reset();
        m_even = 1'b1;
        m_in_frame = 1'b0;
        m_fc = 16'd0;
        m_ec = 0;
        tail_os.delete();
        tail_oct.delete();
    endtask

    // Predict the output slot produced by the next clock edge.
    task automatic model_step(input logic en, input logic er,
                              input logic [7:0] d);
        exp_t e;
        logic ne;
        ne = ~m_even;
        if (tail_os.size() > 0) begin
            e.os = tail_os.pop_front();
            e.oct = tail_oct.pop_front();
        end else if (m_in_frame) begin
            if (en) begin
                e.os = 5'b01000;
                e.oct = d;
                if (er && m_ec < 255) m_ec++;
            end else begin
                e.os = 5'b00100;
                e.oct = 8'hFD;
                m_fc = m_fc + 16'd1;
                m_in_frame = 1'b0;
                // R slots until the next slot is even, then a full /I/
                tail_os.push_back(5'b00001);
                tail_oct.push_back(8'hF7);
                if (!ne) begin
                    tail_os.push_back(5'b00001);
                    tail_oct.push_back(8'hF7);
                end
                tail_os.push_back(5'b10000);
                tail_oct.push_back(8'hBC);
                tail_os.push_back(5'b10000);
                tail_oct.push_back(8'hBC);
            end
        end else if (en && ne) begin
            e.os = 5'b00010;
            e.oct = 8'hFB;
            m_in_frame = 1'b1;
        end else begin
            e.os = 5'b10000;
            e.oct = 8'hBC;
        end
        m_even = ne;
        e.ev = ne;
        e.fc = m_fc;
        e.ec = m_ec[7:0];
        exp_q.push_back(e);
    endtask

    task automatic push_reset_exp();
        exp_t e;
        e.os = 5'b10000;
        e.oct = 8'hBC;
        e.ev = 1'b1;
        e.fc = 16'd0;
        e.ec = 8'd0;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every output slot against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.tx_o_set !== e.os || bus.TXD_out !== e.oct ||
                bus.tx_even !== e.ev || bus.tx_frame_count !== e.fc ||
                bus.tx_err_count !== e.ec) begin
                errors++;
                $display("FAIL slot cyc=%0d got os=%b oct=%h ev=%b fc=%0d ec=%0d want os=%b oct=%h ev=%b fc=%0d ec=%0d",
                         cyc, bus.tx_o_set, bus.TXD_out, bus.tx_even,
                         bus.tx_frame_count, bus.tx_err_count,
                         e.os, e.oct, e.ev, e.fc, e.ec);
            end
        end
    end

    task automatic drive(input logic en, input logic er,
                         input logic [7:0] d);
        @(negedge clk);
        #1;
        rst = 1'b0;
        bus.TX_EN = en;
        bus.TX_ER = er;
        bus.TXD = d;
        model_step(en, er, d);
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            rst = 1'b1;
            bus.TX_EN = 1'b0;
            bus.TX_ER = 1'b0;
            model_reset();
            if (i == 0) begin
                // Asynchronous: reset values must appear without a clock edge
                #1;
                checks++;
                if (bus.tx_o_set !== 5'b10000 || bus.TXD_out !== 8'hBC ||
                    bus.tx_even !== 1'b1 || bus.tx_frame_count !== 16'd0 ||
                    bus.tx_err_count !== 8'd0) begin
                    errors++;
                    $display("FAIL async_reset got os=%b oct=%h ev=%b fc=%0d ec=%0d want os=10000 oct=bc ev=1 fc=0 ec=0",
                             bus.tx_o_set, bus.TXD_out, bus.tx_even,
                             bus.tx_frame_count, bus.tx_err_count);
                end
            end
            push_reset_exp();
        end
    endtask

    task automatic idle_until(input logic want_even);
        int guard;
        guard = 0;
        while (!(m_even == want_even && tail_os.size() == 0 &&
                 !m_in_frame) && guard < 20) begin
            drive(1'b0, 1'b0, 8'h00);
            guard++;
        end
    endtask

    task automatic send(input logic [7:0] pl[$], input logic er);
        foreach (pl[i]) drive(1'b1, er, pl[i]);
        drive(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        logic [7:0] pl[$];
        bus.TX_EN = 1'b0;
        bus.TX_ER = 1'b0;
        bus.TXD = 8'h00;

        // Reset and idle
        reset_cycles(3);
        repeat (10) drive(1'b0, 1'b0, 8'h00);

        // Even-aligned frame: start sampled in IDLE_2
        pl = '{8'h55, 8'h55, 8'hD5, 8'h1B, 8'h1C};
        idle_until(1'b0);
        send(pl, 1'b0);
        repeat (4) drive(1'b0, 1'b0, 8'h00);

        // Late start: start sampled in IDLE_1
        idle_until(1'b1);
        send(pl, 1'b0);
        repeat (4) drive(1'b0, 1'b0, 8'h00);

        // End parity: 4- and 5-octet payloads
        pl = '{8'h01, 8'h02, 8'h03, 8'h04};
        idle_until(1'b0);
        send(pl, 1'b0);
        pl = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        idle_until(1'b0);
        send(pl, 1'b1);
        repeat (4) drive(1'b0, 1'b0, 8'h00);

        // TX_EN asserted during EOP/EPD/IDLE_1 must not shorten the gap
        pl = '{8'hA0, 8'hA1, 8'hA2};
        idle_until(1'b0);
        foreach (pl[i]) drive(1'b1, 1'b0, pl[i]);
        drive(1'b0, 1'b0, 8'h00);
        repeat (8) drive(1'b1, 1'b0, 8'($urandom));
        drive(1'b0, 1'b0, 8'h00);
        repeat (4) drive(1'b0, 1'b0, 8'h00);

        // Carrier extend is idle
        repeat (8) drive(1'b0, 1'b1, 8'($urandom));

        // Random frames with random gaps and errors
        for (int f = 0; f < 40; f++) begin
            int len;
            int gap;
            len = $urandom_range(1, 12);
            gap = $urandom_range(0, 6);
            for (int g = 0; g < gap; g++)
                drive(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
            for (int b = 0; b < len; b++)
                drive(1'b1, ($urandom_range(0, 7) == 0), 8'($urandom));
        end

        // Fully random per-cycle stimulus
        for (int c = 0; c < 300; c++)
            drive(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  8'($urandom));
        repeat (6) drive(1'b0, 1'b0, 8'h00);

        // Error saturation: 300 data slots with TX_ER
        idle_until(1'b0);
        for (int b = 0; b < 300; b++) drive(1'b1, 1'b1, 8'($urandom));
        drive(1'b0, 1'b0, 8'h00);
        repeat (6) drive(1'b0, 1'b0, 8'h00);

        // Reset mid-frame
        idle_until(1'b0);
        for (int b = 0; b < 4; b++) drive(1'b1, 1'b0, 8'($urandom));
        reset_cycles(2);
        repeat (8) drive(1'b0, 1'b0, 8'h00);

        // Drain
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
